fpdivsqrt_arbiter: RTL

FPDIVSQRT_ARBITER -- requirements
Module: fpdivsqrt_arbiter

---
 rtl/fpdivsqrt_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpdivsqrt_arbiter.sv
// fpdivsqrt_arbiter
//   Shares a single FP divide/square-root unit between NUM_REQ requesters.
//   A round-robin grant in IDLE latches the winner's operands, the latched
//   operation is presented to the unit (ISSUE), and the unit's result is
//   routed back to the owning requester (WAIT). A flush aborts the
//   in-flight operation through a one-cycle DRAIN state. A sticky hang flag
//   is raised when the unit takes TIMEOUT_CYC WAIT cycles without finishing.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-requester request handshake (ready is one-hot)
//   req_fp_format_i, req_is_fdiv_i, req_opa_i, req_opb_i, req_rm_i
//                         packed per-requester operation fields, slice k = requester k
//   flush_i               abort the operation in ISSUE or WAIT
//   start_*/fp_format_o/is_fdiv_o/opa_o/opb_o/rm_o/flush_o
//                         start side of the divsqrt unit
//   finish_valid_i/finish_ready_o/res_i/fflags_i
//                         finish side of the divsqrt unit
//   rsp_valid_o/rsp_ready_i  one-hot response handshake to the owner
//   rsp_res_o, rsp_fflags_o  shared response data bus
//   timeout_o             sticky hang flag (cleared only by reset)
//   done_cnt_o            number of delivered responses (wraps)

module fpdivsqrt_arbiter_chk #(
   parameter int NUM_REQ = 2
) (
   input logic               clk,
   input logic               rst_n,
   input logic               is_idle,
   input logic [NUM_REQ-1:0] req_ready,
   input logic [NUM_REQ-1:0] rsp_valid,
   input logic               start_valid,
   input logic               flush
);

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(rsp_valid));

   a_grant_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
      !is_idle |-> (req_ready == {NUM_REQ{1'b0}}));

   a_flush_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      flush |-> (!start_valid && (rsp_valid == {NUM_REQ{1'b0}})));

endmodule

module fpdivsqrt_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [2*NUM_REQ-1:0]   req_fp_format_i,
   input  logic [NUM_REQ-1:0]     req_is_fdiv_i,
   input  logic [64*NUM_REQ-1:0]  req_opa_i,
   input  logic [64*NUM_REQ-1:0]  req_opb_i,
   input  logic [3*NUM_REQ-1:0]   req_rm_i,
   input  logic                   flush_i,
   output logic                   start_valid_o,
   input  logic                   start_ready_i,
   output logic [1:0]             fp_format_o,
   output logic                   is_fdiv_o,
   output logic [63:0]            opa_o,
   output logic [63:0]            opb_o,
   output logic [2:0]             rm_o,
   output logic                   flush_o,
   input  logic                   finish_valid_i,
   output logic                   finish_ready_o,
   input  logic [63:0]            res_i,
   input  logic [4:0]             fflags_i,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   input  logic [NUM_REQ-1:0]     rsp_ready_i,
   output logic [63:0]            rsp_res_o,
   output logic [4:0]             rsp_fflags_o,
   output logic                   timeout_o,
   output logic [31:0]            done_cnt_o
);

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  rr_ptr;
   logic [1:0]  owner;
   logic [1:0]  grant_idx;
   logic        grant_any;
   logic [3:0]  valid_pad;

   logic [1:0]  sel_fmt;
   logic        sel_div;
   logic [63:0] sel_opa;
   logic [63:0] sel_opb;
   logic [2:0]  sel_rm;

   logic [1:0]  lat_fmt;
   logic        lat_div;
   logic [63:0] lat_opa;
   logic [63:0] lat_opb;
   logic [2:0]  lat_rm;

   logic        owner_rsp_ready;
   logic [15:0] wait_cnt;
   logic        timeout;
   logic [31:0] done_cnt;
   logic        flush_pend;

   logic        grant_hs;
   logic        start_hs;
   logic        finish_hs;
   logic        flush_act;
   logic        is_idle;

   // Zero-extend so the rotating index may address up to four requesters
   assign valid_pad = 4'(req_valid_i);

   // Round-robin pick: first valid requester at or after rr_ptr
   always_comb begin
      logic [2:0] sum;
      logic [1:0] cand;
      grant_any = 1'b0;
      grant_idx = 2'd0;
      sum       = 3'd0;
      cand      = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum  = {1'b0, rr_ptr} + 3'(i);
         cand = 2'((sum >= 3'(NUM_REQ)) ? (sum - 3'(NUM_REQ)) : sum);
         if (!grant_any && valid_pad[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end else begin
            grant_any = grant_any;
            grant_idx = grant_idx;
         end
      end
   end

   // Select the granted requester's operand slices
   always_comb begin
      sel_fmt = 2'd0;
      sel_div = 1'b0;
      sel_opa = 64'd0;
      sel_opb = 64'd0;
      sel_rm  = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == 2'(k)) begin
            sel_fmt = req_fp_format_i[2*k +: 2];
            sel_div = req_is_fdiv_i[k];
            sel_opa = req_opa_i[64*k +: 64];
            sel_opb = req_opb_i[64*k +: 64];
            sel_rm  = req_rm_i[3*k +: 3];
         end else begin
            sel_fmt = sel_fmt;
            sel_div = sel_div;
            sel_opa = sel_opa;
            sel_opb = sel_opb;
            sel_rm  = sel_rm;
         end
      end
   end

   // Response-ready of the current owner; other requesters' ready bits are ignored
   always_comb begin
      owner_rsp_ready = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner == 2'(k)) begin
            owner_rsp_ready = rsp_ready_i[k];
         end else begin
            owner_rsp_ready = owner_rsp_ready;
         end
      end
   end

   // Handshake-side outputs; flush suppresses the finish side in the same cycle
   // so a racing finish handshake can never deliver a response
   always_comb begin
      req_ready_o    = {NUM_REQ{1'b0}};
      rsp_valid_o    = {NUM_REQ{1'b0}};
      start_valid_o  = 1'b0;
      finish_ready_o = 1'b0;
      case (state)
         IDLE: begin
            for (int k = 0; k < NUM_REQ; k++) begin
               req_ready_o[k] = grant_any && (grant_idx == 2'(k));
            end
         end
         ISSUE: begin
            start_valid_o = 1'b1;
         end
         WAIT: begin
            if (!flush_i) begin
               finish_ready_o = owner_rsp_ready;
               for (int k = 0; k < NUM_REQ; k++) begin
                  rsp_valid_o[k] = finish_valid_i && (owner == 2'(k));
               end
            end else begin
               finish_ready_o = 1'b0;
               rsp_valid_o    = {NUM_REQ{1'b0}};
            end
         end
         DRAIN: begin
            start_valid_o  = 1'b0;
            finish_ready_o = 1'b0;
         end
         default: begin
            start_valid_o  = 1'b0;
            finish_ready_o = 1'b0;
         end
      endcase
   end

   assign is_idle   = (state == IDLE);
   assign grant_hs  = is_idle && grant_any;
   assign flush_act = ((state == ISSUE) || (state == WAIT)) && flush_i;
   assign start_hs  = (state == ISSUE) && start_ready_i && !flush_i;
   assign finish_hs = (state == WAIT) && finish_valid_i && finish_ready_o;

   // Next-state logic; flush wins over a same-cycle start or finish handshake
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_any) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (flush_i) begin
               state_nxt = DRAIN;
            end else if (start_ready_i) begin
               state_nxt = WAIT;
            end else begin
               state_nxt = ISSUE;
            end
         end
         WAIT: begin
            if (flush_i) begin
               state_nxt = DRAIN;
            end else if (finish_hs) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT;
            end
         end
         DRAIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the winner's operation and advance the round-robin pointer on grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= 2'd0;
         owner   <= 2'd0;
         lat_fmt <= 2'd0;
         lat_div <= 1'b0;
         lat_opa <= 64'd0;
         lat_opb <= 64'd0;
         lat_rm  <= 3'd0;
      end else if (grant_hs) begin
         rr_ptr  <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : (grant_idx + 2'd1);
         owner   <= grant_idx;
         lat_fmt <= sel_fmt;
         lat_div <= sel_div;
         lat_opa <= sel_opa;
         lat_opb <= sel_opb;
         lat_rm  <= sel_rm;
      end
   end

   // Hang detection: count stalled WAIT cycles, saturate, and latch the flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 16'd0;
         timeout  <= 1'b0;
      end else if (start_hs) begin
         wait_cnt <= 16'd0;
      end else if ((state == WAIT) && !finish_hs) begin
         if (wait_cnt < TMO) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         // The increment this cycle reaches the limit
         if (wait_cnt >= (TMO - 16'd1)) begin
            timeout <= 1'b1;
         end
      end
   end

   // Completed-response counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= 32'd0;
      end else if (finish_hs) begin
         done_cnt <= done_cnt + 32'd1;
      end
   end

   // One-cycle flush pulse to the unit, issued the cycle after an accepted flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend <= 1'b0;
      end else begin
         flush_pend <= flush_act;
      end
   end

   assign fp_format_o  = lat_fmt;
   assign is_fdiv_o    = lat_div;
   assign opa_o        = lat_opa;
   assign opb_o        = lat_opb;
   assign rm_o         = lat_rm;
   assign flush_o      = flush_pend;
   assign rsp_res_o    = res_i;
   assign rsp_fflags_o = fflags_i;
   assign timeout_o    = timeout;
   assign done_cnt_o   = done_cnt;

   fpdivsqrt_arbiter_chk #(
      .NUM_REQ (NUM_REQ)
   ) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .is_idle     (is_idle),
      .req_ready   (req_ready_o),
      .rsp_valid   (rsp_valid_o),
      .start_valid (start_valid_o),
      .flush       (flush_o)
   );

endmodule
